qam16_tx_mapper: RTL and testbench
==================================

# qam16_tx_mapper

Transmit-side symbol mapper and upsampler for the 16-QAM modem. It accepts 4-bit data words through a valid/ready handshake and buffers them in a 2-entry FIFO. Each word is Gray-mapped to signed I/Q amplitude levels, and each symbol is emitted for OSR sample-enable cycles. The output feeds the transmit pulse-shaping filter and upconversion stage, which mirror the receiver's CORDIC derotation chain.

## Interface
- DATA_WIDTH, 12: signed width of i_out/q_out.
- OSR, 8: samples per symbol. Legal range is 2..16.
- LEVEL, 512: unit amplitude. 3*LEVEL must fit in signed DATA_WIDTH.

- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ce  input  1  sample-rate enable; one ce-high cycle is one output sample.
- din  input  4  data word; bits[3:2] select I, bits[1:0] select Q.
- din_valid  input  1  din is valid.
- din_ready  output  1  FIFO can accept a word (count < 2).
- zero_stuff  input  1  1: impulse mode; 0: hold mode. Sampled at each ce.
- i_out  output  DATA_WIDTH  signed I sample, registered.
- q_out  output  DATA_WIDTH  signed Q sample, registered.
- sample_valid  output  1  i_out/q_out updated this cycle.
- symbol_strobe  output  1  current sample is phase 0 of a symbol.
- underrun  output  1  one-cycle pulse: symbol boundary reached with FIFO empty.
- ready  output  1  sticky; set once the first symbol has been emitted.

## Operation
- Reset values:
  - FIFO is empty, and din_ready=1.
  - State is IDLE, and the phase counter is 0.
  - i_out=q_out=0, sample_valid=0, symbol_strobe=0, underrun=0, ready=0.
- Write side:
  - A word is accepted on any clk edge where din_valid && din_ready, independent of ce.
  - din_ready is decoded from the registered FIFO count.
  - There is no bypass: a word written at edge k is poppable no earlier than edge k+1.
- Gray map, applied to each 2-bit field: 00 -> -3*LEVEL, 01 -> -LEVEL, 11 -> +LEVEL, 10 -> +3*LEVEL. Results are sign-extended to DATA_WIDTH.
- Phase counter:
  - Width is $clog2(OSR).
  - Increments only on ce in RUN, and wraps from OSR-1 to 0.
- State machine:
  - IDLE: phase is held at 0, outputs stay 0, and ce is ignored. On a ce cycle with FIFO count > 0, pop one word, load it, go to RUN, and set ready.
  - RUN, ce with phase == OSR-1 (symbol boundary):
    - If the FIFO is non-empty, pop and load the next symbol.
    - If it is empty, load I=Q=0 and pulse underrun.
    - Stay in RUN in both cases; there is never a return to IDLE except via reset.
  - RUN, other ce cycles: the loaded symbol is kept.
- Output value per ce in RUN, at the new phase p:
  - Hold mode: the current symbol's levels.
  - Impulse mode: the levels when p == 0, otherwise 0.
- Simultaneous push and pop on a full FIFO: the push is refused because din_ready was already 0. The count drops to 1, and din_ready rises the next cycle.
- Simultaneous push and pop with count 1: the count stays 1, and FIFO order is preserved.
- ce low: outputs, phase and the symbol are frozen, and sample_valid=0. FIFO writes still proceed.

## Timing
- All outputs are registered. sample_valid is high exactly in the cycle after each ce edge processed in RUN, including the IDLE->RUN transition edge.
- symbol_strobe coincides with sample_valid when the emitted phase is 0. underrun coincides with the symbol_strobe of the zero symbol.
- Latency: a word written at edge k into an empty FIFO while in IDLE, with ce high at edge k+1, appears on i_out/q_out after edge k+1.
- Symbol period is exactly OSR ce cycles. The 2-entry FIFO sustains full rate when the source responds within OSR-1 clk cycles.
- ready rises together with the first sample_valid and stays high until rst_n.
- rst_n low at any time: all state clears immediately to the reset values, and buffered words are discarded.

## Test plan
- Reset: hold rst_n low mid-run, then release. Require all outputs at their reset values, din_ready=1, and ready=0.
- Single symbol, OSR=8, hold mode, ce every cycle, din=4'b1001:
  - Require i_out=+1536 and q_out=-512 for 8 consecutive sample_valid cycles, with symbol_strobe on the first.
  - Next, require underrun=1 with i_out=q_out=0.
- Impulse mode stream 0000, 1111, 0110 back-to-back:
  - Require phase-0 samples (-1536,-1536), (+512,+512), (-512,+1536).
  - All other samples are 0, with no underrun.
- Backpressure, ce held low: offer 3 words. Require 2 to be accepted, din_ready=0 after the second accept, and the third held until the first pop.
- Sparse ce, one ce per 3 clk: require each symbol to span 8 ce cycles (24 clk), outputs frozen between ce, and sample_valid only after ce edges.
- Full-FIFO pop/push in the same cycle: require the push refused, din_ready high the next cycle, and the output order matching the input order.

Source files
------------

// File: rtl/qam16_tx_mapper.sv
// 16-QAM transmit mapper: 2-entry input FIFO, Gray map to signed I/Q levels,
// and per-symbol upsampling by OSR in hold or impulse (zero-stuff) mode.
module qam16_tx_mapper #(
  parameter int DATA_WIDTH = 12,
  parameter int OSR        = 8,
  parameter int LEVEL      = 512
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ce,
  input  logic [3:0]                   din,
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic                         zero_stuff,
  output logic signed [DATA_WIDTH-1:0] i_out,
  output logic signed [DATA_WIDTH-1:0] q_out,
  output logic                         sample_valid,
  output logic                         symbol_strobe,
  output logic                         underrun,
  output logic                         ready
);

  localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(OSR - 1);
  localparam logic signed [DATA_WIDTH-1:0] LVL1 = DATA_WIDTH'(LEVEL);
  localparam logic signed [DATA_WIDTH-1:0] LVL3 = DATA_WIDTH'(3 * LEVEL);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic signed [DATA_WIDTH-1:0] gray_level(input logic [1:0] bits);
    logic signed [DATA_WIDTH-1:0] lvl;
    lvl = '0;
    case (bits)
      2'b00:   lvl = -LVL3;
      2'b01:   lvl = -LVL1;
      2'b11:   lvl = LVL1;
      default: lvl = LVL3;
    endcase
    return lvl;
  endfunction

  logic [1:0][3:0] mem_q, mem_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic [0:0]      state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic signed [DATA_WIDTH-1:0] sym_i_q, sym_i_d, sym_q_q, sym_q_d;
  logic signed [DATA_WIDTH-1:0] i_out_q, i_out_d, q_out_q, q_out_d;
  logic sample_valid_q, sample_valid_d;
  logic symbol_strobe_q, symbol_strobe_d;
  logic underrun_q, underrun_d;
  logic ready_q, ready_d;

  logic       push, pop, fifo_nonempty, boundary, emit;
  logic [3:0] head;

  assign din_ready     = (count_q < 2'd2);
  assign push          = din_valid && din_ready;
  assign fifo_nonempty = (count_q != 2'd0);
  assign boundary      = (phase_q == LAST_PHASE);
  assign head          = mem_q[rd_ptr_q];
  // Pops only see the registered count, so a word written this edge is never popped this edge.
  assign pop           = ce && fifo_nonempty && ((state_q == ST_IDLE) || boundary);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    sym_i_d         = sym_i_q;
    sym_q_d         = sym_q_q;
    i_out_d         = i_out_q;
    q_out_d         = q_out_q;
    sample_valid_d  = 1'b0;
    symbol_strobe_d = 1'b0;
    underrun_d      = 1'b0;
    ready_d         = ready_q;
    emit            = 1'b0;
    if (ce) begin
      if (state_q == ST_IDLE) begin
        if (fifo_nonempty) begin
          state_d = ST_RUN;
          phase_d = '0;
          sym_i_d = gray_level(head[3:2]);
          sym_q_d = gray_level(head[1:0]);
          ready_d = 1'b1;
          emit    = 1'b1;
        end
      end else begin
        emit = 1'b1;
        if (boundary) begin
          phase_d = '0;
          if (fifo_nonempty) begin
            sym_i_d = gray_level(head[3:2]);
            sym_q_d = gray_level(head[1:0]);
          end else begin
            sym_i_d    = '0;
            sym_q_d    = '0;
            underrun_d = 1'b1;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
    end
    if (emit) begin
      sample_valid_d  = 1'b1;
      symbol_strobe_d = (phase_d == '0);
      // Impulse mode emits the symbol only on phase 0 and zeros elsewhere.
      if (zero_stuff && (phase_d != '0)) begin
        i_out_d = '0;
        q_out_d = '0;
      end else begin
        i_out_d = sym_i_d;
        q_out_d = sym_q_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q           <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      state_q         <= ST_IDLE;
      phase_q         <= '0;
      sym_i_q         <= '0;
      sym_q_q         <= '0;
      i_out_q         <= '0;
      q_out_q         <= '0;
      sample_valid_q  <= 1'b0;
      symbol_strobe_q <= 1'b0;
      underrun_q      <= 1'b0;
      ready_q         <= 1'b0;
    end else begin
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      state_q         <= state_d;
      phase_q         <= phase_d;
      sym_i_q         <= sym_i_d;
      sym_q_q         <= sym_q_d;
      i_out_q         <= i_out_d;
      q_out_q         <= q_out_d;
      sample_valid_q  <= sample_valid_d;
      symbol_strobe_q <= symbol_strobe_d;
      underrun_q      <= underrun_d;
      ready_q         <= ready_d;
    end
  end

  assign i_out         = i_out_q;
  assign q_out         = q_out_q;
  assign sample_valid  = sample_valid_q;
  assign symbol_strobe = symbol_strobe_q;
  assign underrun      = underrun_q;
  assign ready         = ready_q;

endmodule

// File: tb/tb_qam16_tx_mapper.sv
// Directed-vector bench for qam16_tx_mapper (DATA_WIDTH=12, OSR=8, LEVEL=512).
module tb_qam16_tx_mapper;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ce = 1'b0;
  logic [3:0]        din = 4'd0;
  logic              din_valid = 1'b0;
  logic              din_ready;
  logic              zero_stuff = 1'b0;
  logic signed [11:0] i_out, q_out;
  logic              sample_valid, symbol_strobe, underrun, ready;

  int checks = 0;
  int errors = 0;

  qam16_tx_mapper #(.DATA_WIDTH(12), .OSR(8), .LEVEL(512)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .zero_stuff(zero_stuff), .i_out(i_out), .q_out(q_out),
    .sample_valid(sample_valid), .symbol_strobe(symbol_strobe),
    .underrun(underrun), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       ce;
    logic       dv;
    logic [3:0] din;
    logic       zs;
    logic       exp_dr;
    int         exp_i;
    int         exp_q;
    logic       exp_sv;
    logic       exp_ss;
    logic       exp_un;
    logic       exp_rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input string name, input logic c, input logic dv, input logic [3:0] d,
                        input logic zs, input logic dr, input int ei, input int eq,
                        input logic sv, input logic ss, input logic un, input logic rdy);
    vec_t v;
    v.name = name; v.ce = c; v.dv = dv; v.din = d; v.zs = zs;
    v.exp_dr = dr; v.exp_i = ei; v.exp_q = eq;
    v.exp_sv = sv; v.exp_ss = ss; v.exp_un = un; v.exp_rdy = rdy;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic c, input logic dv, input logic [3:0] d, input logic zs);
    ce = c; din_valid = dv; din = d; zero_stuff = zs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic dr, input int ei, input int eq,
                             input logic sv, input logic ss, input logic un, input logic rdy);
    logic [28:0] act, expv;
    act  = {din_ready, i_out, q_out, sample_valid, symbol_strobe, underrun, ready};
    expv = {dr, 12'(ei), 12'(eq), sv, ss, un, rdy};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got dr=%0b i=%0d q=%0d sv=%0b ss=%0b un=%0b rdy=%0b, want dr=%0b i=%0d q=%0d sv=%0b ss=%0b un=%0b rdy=%0b",
               name, din_ready, i_out, q_out, sample_valid, symbol_strobe, underrun, ready,
               dr, ei, eq, sv, ss, un, rdy);
    end
  endtask

  task automatic runTable();
    foreach (vecs[n]) begin
      applyStimulus(vecs[n].ce, vecs[n].dv, vecs[n].din, vecs[n].zs);
      tick();
      checkOutput(vecs[n].name, vecs[n].exp_dr, vecs[n].exp_i, vecs[n].exp_q,
                  vecs[n].exp_sv, vecs[n].exp_ss, vecs[n].exp_un, vecs[n].exp_rdy);
    end
    vecs.delete();
  endtask

  task automatic doReset(input string name);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    #3 rst_n = 1'b0;
    #1 checkOutput({name, "_async"}, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput({name, "_released"}, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  int wi[5] = '{-1536, -1536, -512, 512, 0};
  int wq[5] = '{-512, 1536, 512, -512, 0};

  initial begin
    int ce_idx;
    int si;
    logic c;

    $display("[TB] start");
    #2;
    checkOutput("reset_initial", 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single 1001 symbol in hold mode, then underrun zero symbol.
    addVec("hold_write", 1, 1, 4'b1001, 0, 1, 0, 0, 0, 0, 0, 0);
    addVec("hold_p0", 1, 0, 4'd0, 0, 1, 1536, -512, 1, 1, 0, 1);
    for (int p = 1; p < 8; p++) addVec("hold_pn", 1, 0, 4'd0, 0, 1, 1536, -512, 1, 0, 0, 1);
    addVec("underrun", 1, 0, 4'd0, 0, 1, 0, 0, 1, 1, 1, 1);
    addVec("zero_p1", 1, 0, 4'd0, 0, 1, 0, 0, 1, 0, 0, 1);
    runTable();

    doReset("reset_midrun");

    // Backpressure with ce low, then impulse-mode stream 0000, 1111, 0110.
    addVec("bp_w0", 0, 1, 4'b0000, 1, 1, 0, 0, 0, 0, 0, 0);
    addVec("bp_w1", 0, 1, 4'b1111, 1, 0, 0, 0, 0, 0, 0, 0);
    addVec("bp_w2_held", 0, 1, 4'b0110, 1, 0, 0, 0, 0, 0, 0, 0);
    addVec("imp_s0", 1, 1, 4'b0110, 1, 1, -1536, -1536, 1, 1, 0, 1);
    addVec("imp_w2_acc", 1, 1, 4'b0110, 1, 0, 0, 0, 1, 0, 0, 1);
    for (int p = 2; p < 8; p++) addVec("imp_s0_zero", 1, 0, 4'd0, 1, 0, 0, 0, 1, 0, 0, 1);
    addVec("imp_s1", 1, 0, 4'd0, 1, 1, 512, 512, 1, 1, 0, 1);
    for (int p = 1; p < 8; p++) addVec("imp_s1_zero", 1, 0, 4'd0, 1, 1, 0, 0, 1, 0, 0, 1);
    addVec("imp_s2", 1, 0, 4'd0, 1, 1, -512, 1536, 1, 1, 0, 1);
    for (int p = 1; p < 8; p++) addVec("imp_s2_zero", 1, 0, 4'd0, 1, 1, 0, 0, 1, 0, 0, 1);
    runTable();

    doReset("reset_pre_sparse");

    // Sparse ce: A=1100 (+512,-1536) then B=0110 (-512,+1536), one ce per 3 clk.
    applyStimulus(0, 1, 4'b1100, 0); tick();
    checkOutput("sparse_wA", 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 4'b0110, 0); tick();
    checkOutput("sparse_wB", 0, 0, 0, 0, 0, 0, 0);
    ce_idx = 0;
    for (int k = 0; k < 48; k++) begin
      c = (k % 3 == 0);
      applyStimulus(c, 0, 4'd0, 0);
      tick();
      if (c) ce_idx++;
      checkOutput("sparse", 1,
                  (ce_idx <= 8) ? 512 : -512, (ce_idx <= 8) ? -1536 : 1536,
                  c, c && ((ce_idx - 1) % 8 == 0), 1'b0, 1'b1);
    end

    doReset("reset_pre_full");

    // Full-FIFO pop with refused push, later push+pop at count 1; order W0..W3.
    applyStimulus(0, 1, 4'b0001, 0); tick();
    checkOutput("full_w0", 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 4'b0010, 0); tick();
    checkOutput("full_w1", 0, 0, 0, 0, 0, 0, 0);
    for (int e = 3; e <= 35; e++) begin
      if (e == 3 || e == 4) applyStimulus(1, 1, 4'b0111, 0);
      else if (e == 19)     applyStimulus(1, 1, 4'b1101, 0);
      else                  applyStimulus(1, 0, 4'd0, 0);
      tick();
      si = (e - 3) / 8;
      checkOutput("full_order", !(e >= 4 && e <= 10), wi[si], wq[si],
                  1'b1, ((e - 3) % 8 == 0), (e == 35), 1'b1);
    end

    // Reset while running with buffered words; they must be discarded.
    applyStimulus(0, 1, 4'b1111, 0); tick();
    applyStimulus(0, 1, 4'b0000, 0); tick();
    checkOutput("prefill_full", 0, 0, 0, 0, 0, 0, 1);
    doReset("reset_discard");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 4'd0, 0);
      tick();
      checkOutput("post_reset_idle", 1, 0, 0, 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
